vram_write_arbiter: RTL and testbench
=====================================

# vram_write_arbiter

Shares the single VRAM access port between the CPU write path and the GPU renderer fetch path, in the `gpu_clk` domain. CPU writes are buffered in a small FIFO so the CPU never stalls. The renderer gets priority during active display, and buffered writes drain in vblank or when a starvation limit is reached. It sits between the address-decoded CPU write strobe (`vram_address_t`/`data_t`) and the VRAM memories inside the GPU.

## Interface
- `FIFO_DEPTH`, 4: CPU write buffer entries; power of two, at least 2.
- `STARVE_LIMIT`, 8: consecutive cycles a pending write may lose arbitration before it is forced.
- `gpu_clk`  in  1  sole clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `cpu_wr_valid_i`  in  1  one-cycle push strobe.
- `cpu_wr_address_i`  in  12  `mapache64::vram_address_t`.
- `cpu_wr_data_i`  in  8  `mapache64::data_t`.
- `cpu_wr_ready_o`  out  1  FIFO not full.
- `overflow_o`  out  1  sticky: a push was dropped.
- `clr_overflow_i`  in  1  clears `overflow_o`.
- `pending_o`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `in_vblank_i`  in  1  level, from the GPU timing generator.
- `render_req_i`  in  1  renderer read request, level, held until granted.
- `render_address_i`  in  12  read address.
- `render_gnt_o`  out  1  request accepted this cycle.
- `render_data_o`  out  8  read data.
- `render_data_valid_o`  out  1  `render_data_o` valid.
- `vram_address_o`  out  12  registered.
- `vram_wen_o`  out  1  registered.
- `vram_ren_o`  out  1  registered.
- `vram_wdata_o`  out  8  registered.
- `vram_rdata_i`  in  8  valid the cycle after `vram_ren_o`.

## Operation
- **FIFO.** Circular buffer with head and tail pointers of $clog2(FIFO_DEPTH) bits, wrapping naturally. `pending_o` is the count.
- **Push.** A push is accepted when `cpu_wr_valid_i && !full`.
- **Push while full.** The push is dropped and `overflow_o` is set, even if a pop happens the same cycle.
- **Pop.** A pop occurs when the write is granted. Push and pop in the same cycle (not full) leave the count unchanged.
- **Overflow flag.** `clr_overflow_i` clears `overflow_o`. If it coincides with a new drop, set wins.
- **Arbitration.** Evaluated every cycle on registered state. Exactly one grant per cycle, or idle.
  - WRITE when FIFO nonempty and any of: `in_vblank_i`; `!render_req_i`; `starve_cnt == STARVE_LIMIT-1`.
  - Otherwise READ when `render_req_i`.
  - Otherwise IDLE.
- **Starvation counter.**
  - Increments each cycle the FIFO is nonempty and READ wins.
  - Resets to 0 on any WRITE grant or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT-1`.
- **WRITE grant.** On the next edge, `vram_wen_o`=1, `vram_address_o`/`vram_wdata_o` = head entry, `vram_ren_o`=0, and the head advances.
- **READ grant.** On the next edge, `vram_ren_o`=1, `vram_address_o`=`render_address_i`, `render_gnt_o`=1.
- **Read return.** One cycle after `vram_ren_o`, `render_data_valid_o`=1 and `render_data_o` is captured from `vram_rdata_i`.
- **IDLE.** `vram_wen_o`, `vram_ren_o` and `render_gnt_o` are 0. The address and wdata outputs hold their last value.
- **Forwarding.** There is no read-after-write forwarding. A render read may return stale data for an address still in the FIFO; this is accepted by design.

## Timing
- **Reset values.**
  - All `vram_*` outputs 0.
  - `render_gnt_o`, `render_data_valid_o` and `render_data_o` are 0.
  - `overflow_o`=0, `pending_o`=0, `cpu_wr_ready_o`=1.
  - FIFO empty, `starve_cnt`=0.
- **Reset mid-operation.** Reset takes effect immediately and discards FIFO contents and any in-flight read. `render_data_valid_o` must not pulse after reset deasserts for a read issued before reset.
- **Write latency.** Push at edge k; earliest `vram_wen_o` is the cycle after edge k+1.
- **Read latency.** `render_req_i` high before edge k, if it wins: `render_gnt_o` and `vram_ren_o` are high after edge k, and `render_data_valid_o` is high after edge k+1.
- **Back-to-back reads.** A read every cycle is allowed.
- **Request hold.** The renderer drops `render_req_i` or changes address only after seeing `render_gnt_o`.
- **Worst-case write wait.** During active display with continuous reads, a pending write issues within `STARVE_LIMIT` cycles.

## Test plan
- **Reset.** Assert `rst_ni`=0 mid-traffic (FIFO holding 3 entries, read in flight) -> all outputs at reset values within the same cycle; `pending_o`=0; no `render_data_valid_o` afterwards.
- **Vblank drain.** `in_vblank_i`=1, `render_req_i`=1; push 4 writes (addr 0x000..0x003, data 0xA0..0xA3) -> 4 consecutive `vram_wen_o` cycles in order; no `render_gnt_o` until the FIFO is empty; `pending_o` returns to 0.
- **Starvation.** `in_vblank_i`=0, `render_req_i` held 1, one push -> exactly 7 READ grants, then 1 WRITE, then reads resume.
- **Overflow.** Renderer saturating, 5 pushes in 5 cycles with `FIFO_DEPTH`=4 -> `cpu_wr_ready_o`=0 at occupancy 4; 5th push dropped; `overflow_o`=1 until `clr_overflow_i`.
- **Simultaneous push and pop.** Occupancy 2, push and WRITE grant in the same cycle -> `pending_o` stays 2, FIFO order preserved.
- **Read data path.** Idle FIFO, read 0x7FF with VRAM model returning 0x5C -> `render_gnt_o` at cycle t, `render_data_valid_o` with 0x5C at t+1.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// VRAM port arbiter: buffers CPU writes in a small FIFO and shares the single
// VRAM port with renderer reads, favouring reads during active display.
module vram_write_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                              gpu_clk,
    input  logic                              rst_ni,
    input  logic                              cpu_wr_valid_i,
    input  logic [11:0]                       cpu_wr_address_i,
    input  logic [7:0]                        cpu_wr_data_i,
    output logic                              cpu_wr_ready_o,
    output logic                              overflow_o,
    input  logic                              clr_overflow_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_o,
    input  logic                              in_vblank_i,
    input  logic                              render_req_i,
    input  logic [11:0]                       render_address_i,
    output logic                              render_gnt_o,
    output logic [7:0]                        render_data_o,
    output logic                              render_data_valid_o,
    output logic [11:0]                       vram_address_o,
    output logic                              vram_wen_o,
    output logic                              vram_ren_o,
    output logic [7:0]                        vram_wdata_o,
    input  logic [7:0]                        vram_rdata_i
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

    logic [11:0]   fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          overflow_q, overflow_d;

    logic [11:0]   vram_address_q;
    logic [7:0]    vram_wdata_q;
    logic          vram_wen_q, vram_ren_q;
    logic          render_gnt_q;
    logic          render_data_valid_q;
    logic [7:0]    render_data_q;

    logic full, empty, push, grant_write, grant_read;

    always_comb begin
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        push        = cpu_wr_valid_i && !full;
        // Reads win during active display unless the head write has waited too long.
        grant_write = !empty && (in_vblank_i || !render_req_i || (starve_q == STARVE_MAX));
        grant_read  = !grant_write && render_req_i;
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(grant_write);

        starve_d = starve_q;
        if (empty || grant_write) begin
            starve_d = '0;
        end else if (grant_read && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        overflow_d = overflow_q;
        if (cpu_wr_valid_i && full) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge gpu_clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= cpu_wr_address_i;
            fifo_data_q[tail_q] <= cpu_wr_data_i;
        end
    end

    always_ff @(posedge gpu_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            starve_q            <= '0;
            overflow_q          <= 1'b0;
            vram_address_q      <= '0;
            vram_wdata_q        <= '0;
            vram_wen_q          <= 1'b0;
            vram_ren_q          <= 1'b0;
            render_gnt_q        <= 1'b0;
            render_data_valid_q <= 1'b0;
            render_data_q       <= '0;
        end else begin
            count_q    <= count_d;
            starve_q   <= starve_d;
            overflow_q <= overflow_d;
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (grant_write) begin
                head_q <= head_q + PW'(1);
            end

            vram_wen_q   <= grant_write;
            vram_ren_q   <= grant_read;
            render_gnt_q <= grant_read;
            if (grant_write) begin
                vram_address_q <= fifo_addr_q[head_q];
                vram_wdata_q   <= fifo_data_q[head_q];
            end else if (grant_read) begin
                vram_address_q <= render_address_i;
            end

            // VRAM read data arrives one cycle after the read strobe.
            render_data_valid_q <= vram_ren_q;
            if (vram_ren_q) begin
                render_data_q <= vram_rdata_i;
            end
        end
    end

    assign cpu_wr_ready_o      = !full;
    assign overflow_o          = overflow_q;
    assign pending_o           = count_q;
    assign render_gnt_o        = render_gnt_q;
    assign render_data_o       = render_data_q;
    assign render_data_valid_o = render_data_valid_q;
    assign vram_address_o      = vram_address_q;
    assign vram_wen_o          = vram_wen_q;
    assign vram_ren_o          = vram_ren_q;
    assign vram_wdata_o        = vram_wdata_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_vram_write_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic                             gpu_clk = 1'b0;
    logic                             rst_ni  = 1'b0;
    logic                             cpu_wr_valid = 1'b0;
    logic [11:0]                      cpu_wr_address = '0;
    logic [7:0]                       cpu_wr_data = '0;
    logic                             cpu_wr_ready;
    logic                             overflow;
    logic                             clr_overflow = 1'b0;
    logic [$clog2(DEPTH+1)-1:0]       pending;
    logic                             in_vblank = 1'b0;
    logic                             render_req = 1'b0;
    logic [11:0]                      render_address = '0;
    logic                             render_gnt;
    logic [7:0]                       render_data;
    logic                             render_data_valid;
    logic [11:0]                      vram_address;
    logic                             vram_wen;
    logic                             vram_ren;
    logic [7:0]                       vram_wdata;
    logic [7:0]                       vram_rdata;

    logic [7:0] vram_mem [4096];
    assign vram_rdata = vram_mem[vram_address];

    always #5 gpu_clk = ~gpu_clk;

    vram_write_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .gpu_clk            (gpu_clk),
        .rst_ni             (rst_ni),
        .cpu_wr_valid_i     (cpu_wr_valid),
        .cpu_wr_address_i   (cpu_wr_address),
        .cpu_wr_data_i      (cpu_wr_data),
        .cpu_wr_ready_o     (cpu_wr_ready),
        .overflow_o         (overflow),
        .clr_overflow_i     (clr_overflow),
        .pending_o          (pending),
        .in_vblank_i        (in_vblank),
        .render_req_i       (render_req),
        .render_address_i   (render_address),
        .render_gnt_o       (render_gnt),
        .render_data_o      (render_data),
        .render_data_valid_o(render_data_valid),
        .vram_address_o     (vram_address),
        .vram_wen_o         (vram_wen),
        .vram_ren_o         (vram_ren),
        .vram_wdata_o       (vram_wdata),
        .vram_rdata_i       (vram_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of {addr,data} and a count of lost arbitrations.
    logic [19:0] mq [$];
    int          losses;
    bit          m_ovf;
    bit          e_wen, e_ren, e_gnt, e_dv;
    logic [11:0] e_addr;
    logic [7:0]  e_wdata, e_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        losses  = 0;
        m_ovf   = 0;
        e_wen   = 0;
        e_ren   = 0;
        e_gnt   = 0;
        e_dv    = 0;
        e_addr  = '0;
        e_wdata = '0;
        e_rdata = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/wen"},     32'(vram_wen),          32'(e_wen));
        chk({tag, "/ren"},     32'(vram_ren),          32'(e_ren));
        chk({tag, "/gnt"},     32'(render_gnt),        32'(e_gnt));
        chk({tag, "/addr"},    32'(vram_address),      32'(e_addr));
        chk({tag, "/wdata"},   32'(vram_wdata),        32'(e_wdata));
        chk({tag, "/dvalid"},  32'(render_data_valid), 32'(e_dv));
        chk({tag, "/rdata"},   32'(render_data),       32'(e_rdata));
        chk({tag, "/pending"}, 32'(pending),           32'(mq.size()));
        chk({tag, "/ready"},   32'(cpu_wr_ready),      32'(mq.size() != DEPTH));
        chk({tag, "/ovf"},     32'(overflow),          32'(m_ovf));
    endtask

    // Predict one clock edge from the current inputs, then compare after it.
    task automatic cycle(input string tag);
        int          n0;
        bit          full_now, wr, rd;
        logic [19:0] head;
        n0       = mq.size();
        full_now = (n0 == DEPTH);
        wr       = (n0 != 0) && (in_vblank || !render_req || (losses == LIMIT - 1));
        rd       = !wr && render_req;

        e_dv = e_ren;
        if (e_ren) e_rdata = vram_mem[e_addr];
        if (wr) begin
            head    = mq.pop_front();
            e_addr  = head[19:8];
            e_wdata = head[7:0];
        end else if (rd) begin
            e_addr = render_address;
        end
        e_wen = wr;
        e_ren = rd;
        e_gnt = rd;

        if (cpu_wr_valid && !full_now) mq.push_back({cpu_wr_address, cpu_wr_data});
        if (cpu_wr_valid && full_now) m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;

        if (n0 == 0 || wr) losses = 0;
        else if (rd && losses < LIMIT - 1) losses = losses + 1;

        @(posedge gpu_clk);
        #1;
        check_all(tag);
    endtask

    task automatic drain();
        in_vblank    = 1'b1;
        render_req   = 1'b0;
        cpu_wr_valid = 1'b0;
        clr_overflow = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cycle("drain");
        chk("drain_empty", 32'(pending), 32'd0);
    endtask

    int nreads;
    bit seen_w;
    bit resumed;

    initial begin
        for (int i = 0; i < 4096; i++) vram_mem[i] = 8'($urandom);
        vram_mem[12'h7FF] = 8'h5C;
        model_reset();

        // Reset values
        #3;
        check_all("reset");
        @(negedge gpu_clk);
        rst_ni = 1'b1;

        // Read data path
        drain();
        in_vblank      = 1'b0;
        render_req     = 1'b1;
        render_address = 12'h7FF;
        cycle("rd_path");
        chk("rd_path_gnt",  32'(render_gnt),   32'd1);
        chk("rd_path_addr", 32'(vram_address), 32'h7FF);
        render_req = 1'b0;
        cycle("rd_path");
        chk("rd_path_valid", 32'(render_data_valid), 32'd1);
        chk("rd_path_data",  32'(render_data),       32'h5C);

        // Vblank drain: four writes in order, reads held off until empty
        drain();
        in_vblank = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cpu_wr_valid   = (j < 4);
            cpu_wr_address = 12'(j);
            cpu_wr_data    = 8'hA0 + 8'(j);
            render_req     = (j >= 4);
            render_address = 12'h155;
            cycle("vblank");
            if (j >= 1 && j <= 4) begin
                chk("vblank_wen",   32'(vram_wen),     32'd1);
                chk("vblank_addr",  32'(vram_address), 32'(j - 1));
                chk("vblank_wdata", 32'(vram_wdata),   32'(8'hA0 + 8'(j - 1)));
                chk("vblank_nognt", 32'(render_gnt),   32'd0);
            end
        end
        chk("vblank_gnt",     32'(render_gnt), 32'd1);
        chk("vblank_pending", 32'(pending),    32'd0);

        // Starvation: one write waits out LIMIT-1 reads
        drain();
        in_vblank      = 1'b0;
        render_req     = 1'b1;
        render_address = 12'h2AA;
        cpu_wr_valid   = 1'b1;
        cpu_wr_address = 12'h0F0;
        cpu_wr_data    = 8'h3C;
        cycle("starve");
        cpu_wr_valid = 1'b0;
        nreads  = 0;
        seen_w  = 0;
        resumed = 0;
        for (int j = 0; j < 12; j++) begin
            cycle("starve");
            if (!seen_w) begin
                if (vram_wen) seen_w = 1;
                else if (render_gnt) nreads++;
            end else if (!resumed) begin
                chk("starve_resume", 32'(render_gnt), 32'd1);
                resumed = 1;
            end
        end
        chk("starve_reads", 32'(nreads), 32'd7);
        chk("starve_write", 32'(seen_w), 32'd1);

        // Overflow with the renderer saturating the port
        drain();
        in_vblank  = 1'b0;
        render_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cpu_wr_valid   = 1'b1;
            cpu_wr_address = 12'h300 + 12'(j);
            cpu_wr_data    = 8'h50 + 8'(j);
            cycle("ovf");
            if (j == 3) begin
                chk("ovf_ready", 32'(cpu_wr_ready), 32'd0);
                chk("ovf_full",  32'(pending),      32'd4);
            end
        end
        chk("ovf_set",     32'(overflow), 32'd1);
        chk("ovf_dropped", 32'(pending),  32'd4);
        cpu_wr_valid = 1'b0;
        cycle("ovf");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        cycle("ovf");
        clr_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Simultaneous push and pop at occupancy 2
        drain();
        in_vblank  = 1'b0;
        render_req = 1'b1;
        for (int j = 0; j < 2; j++) begin
            cpu_wr_valid   = 1'b1;
            cpu_wr_address = 12'h3E0 + 12'(j);
            cpu_wr_data    = 8'h11 * 8'(j + 1);
            cycle("pushpop");
        end
        chk("pushpop_pre", 32'(pending), 32'd2);
        in_vblank      = 1'b1;
        cpu_wr_address = 12'h3F0;
        cpu_wr_data    = 8'h77;
        cycle("pushpop");
        chk("pushpop_cnt",   32'(pending),    32'd2);
        chk("pushpop_first", 32'(vram_wdata), 32'h11);
        cpu_wr_valid = 1'b0;
        cycle("pushpop");
        chk("pushpop_second", 32'(vram_wdata), 32'h22);
        cycle("pushpop");
        chk("pushpop_third", 32'(vram_wdata), 32'h77);

        // Random traffic
        drain();
        in_vblank = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            cpu_wr_valid   = ($urandom_range(2) == 0);
            cpu_wr_address = 12'($urandom);
            cpu_wr_data    = 8'($urandom);
            clr_overflow   = ($urandom_range(19) == 0);
            if ($urandom_range(15) == 0) in_vblank = ~in_vblank;
            if (!render_req || e_gnt) begin
                render_req     = ($urandom_range(3) != 0);
                render_address = 12'($urandom);
            end
            cycle("rand");
        end

        // Reset mid-traffic: three buffered writes and a read in flight
        drain();
        in_vblank      = 1'b0;
        render_req     = 1'b1;
        render_address = 12'h0AB;
        for (int j = 0; j < 3; j++) begin
            cpu_wr_valid   = 1'b1;
            cpu_wr_address = 12'h100 + 12'(j);
            cpu_wr_data    = 8'hC0 + 8'(j);
            cycle("rstmid");
        end
        chk("rstmid_pending", 32'(pending),  32'd3);
        chk("rstmid_inflight", 32'(vram_ren), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("rstmid_async");
        cpu_wr_valid = 1'b0;
        render_req   = 1'b0;
        @(posedge gpu_clk);
        @(negedge gpu_clk);
        rst_ni = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cycle("rstmid_after");
            chk("rstmid_novalid", 32'(render_data_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
